flasher_sequencer: RTL and testbench

- Programmable sequencer for the 16-LED bound-flasher bar. It owns the LED level register and steps it through a table of up/down phases at a rate set by an external tick.
- It turns the asynchronous `flick` button into a clean event. The event starts a sequence from idle, or kicks the bar back to the previous up phase at configured kick points.
- It provides a small config port for rewriting phase targets between runs, plus busy/done status for the surrounding control logic.

---
 rtl/flasher_sequencer.sv | 160 ++++++++++++++++
 tb/tb_flasher_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/flasher_sequencer.sv
// Bound-flasher bar sequencer: walks a 16-LED level through a rewritable table
// of up/down phase targets, with a synchronized flick button for start and kick-back.
module flasher_sequencer #(
  parameter int LED_W     = 16,
  parameter int LVL_W     = 5,
  parameter int NUM_PHASE = 6,
  parameter int KICK_A    = 0,
  parameter int KICK_B    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flick,
  input  logic             step_en,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [LVL_W-1:0] cfg_data,
  output logic [LED_W-1:0] LED,
  output logic [LVL_W-1:0] led_level,
  output logic [1:0]       current_state,
  output logic [2:0]       current_index,
  output logic             busy,
  output logic             done,
  output logic             kick
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GO_UP   = 2'b01,
    GO_DOWN = 2'b10
  } state_e;

  localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(LED_W);
  localparam logic [LVL_W-1:0] LVL_KA    = LVL_W'(KICK_A);
  localparam logic [LVL_W-1:0] LVL_KB    = LVL_W'(KICK_B);
  localparam logic [2:0]       LAST_IDX  = 3'(NUM_PHASE - 1);
  localparam logic [3:0]       PHASE_CNT = 4'(NUM_PHASE);

  function automatic logic [LVL_W-1:0] default_target(input int idx);
    case (idx)
      0:       return LVL_W'(16);
      1:       return LVL_W'(6);
      2:       return LVL_W'(11);
      3:       return LVL_W'(0);
      4:       return LVL_W'(6);
      default: return '0;
    endcase
  endfunction

  // Flick synchronizer; the third stage only remembers the previous sample for edge detect.
  logic sync1_q, sync2_q, sync3_q;
  logic fev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= flick;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign fev = sync2_q & ~sync3_q;

  state_e           state_q;
  logic [2:0]       index_q;
  logic [LVL_W-1:0] level_q;
  logic             done_q, kick_q;

  // Phase table: one register per entry so reset can restore the defaults.
  logic [NUM_PHASE-1:0][LVL_W-1:0] table_w;
  logic [LVL_W-1:0]                cfg_lvl_d;
  logic                            cfg_ok;

  assign cfg_lvl_d = (cfg_data > LVL_MAX) ? LVL_MAX : cfg_data;
  assign cfg_ok    = cfg_we && (state_q == IDLE) && ({1'b0, cfg_addr} < PHASE_CNT);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PHASE; gi++) begin : g_table
      logic [LVL_W-1:0] entry_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entry_q <= default_target(gi);
        end else if (cfg_ok && (cfg_addr == 3'(gi))) begin
          entry_q <= cfg_lvl_d;
        end
      end
      assign table_w[gi] = entry_q;
    end
  endgenerate

  logic [LVL_W-1:0] tgt;
  logic             at_kick;

  assign tgt     = ({1'b0, index_q} < PHASE_CNT) ? table_w[index_q] : '0;
  assign at_kick = (level_q == LVL_KA) || (level_q == LVL_KB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      index_q <= '0;
      level_q <= '0;
      done_q  <= 1'b0;
      kick_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      kick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fev) begin
            state_q <= GO_UP;
            index_q <= '0;
            level_q <= '0;
          end
        end
        GO_UP, GO_DOWN: begin
          // A kick-back swallows any step that lands in the same cycle.
          if ((state_q == GO_DOWN) && fev && at_kick) begin
            state_q <= GO_UP;
            index_q <= index_q - 3'd1;
            kick_q  <= 1'b1;
          end else if (step_en) begin
            if ((state_q == GO_UP) && (level_q < tgt) && (level_q < LVL_MAX)) begin
              level_q <= level_q + LVL_W'(1);
            end else if ((state_q == GO_DOWN) && (level_q > tgt)) begin
              level_q <= level_q - LVL_W'(1);
            end else if (index_q == LAST_IDX) begin
              state_q <= IDLE;
              index_q <= '0;
              level_q <= '0;
              done_q  <= 1'b1;
            end else begin
              // Next index is even (up phase) exactly when the current one is odd.
              index_q <= index_q + 3'd1;
              state_q <= index_q[0] ? GO_UP : GO_DOWN;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  generate
    for (gi = 0; gi < LED_W; gi++) begin : g_led
      assign LED[gi] = (level_q > LVL_W'(gi));
    end
  endgenerate

  assign led_level     = level_q;
  assign current_state = state_q;
  assign current_index = index_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign kick          = kick_q;

endmodule

// File: tb/tb_flasher_sequencer.sv
// Directed bench for flasher_sequencer: default run, kick-back, config writes,
// wrong-direction targets and asynchronous reset abort.
module tb_flasher_sequencer;

  logic        clk, reset, flick, step_en, cfg_we;
  logic [2:0]  cfg_addr;
  logic [4:0]  cfg_data;
  logic [15:0] LED;
  logic [4:0]  led_level;
  logic [1:0]  current_state;
  logic [2:0]  current_index;
  logic        busy, done, kick;

  int total = 0;
  int bad   = 0;

  flasher_sequencer dut (
    .clk(clk), .reset(reset), .flick(flick), .step_en(step_en),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .LED(LED), .led_level(led_level), .current_state(current_state),
    .current_index(current_index), .busy(busy), .done(done), .kick(kick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_run(input string tag, input int st, input int idx, input int lvl);
    chk({tag, ".state"}, 32'(current_state), st);
    chk({tag, ".index"}, 32'(current_index), idx);
    chk({tag, ".level"}, 32'(led_level), lvl);
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = 3'(addr);
    cfg_data = 5'(data);
    tick(1);
    cfg_we   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flick = 1'b0; step_en = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    tick(2);
    chk_run("rst", 0, 0, 0);
    chk("rst.led", 32'(LED), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.kick", 32'(kick), 0);
    reset = 1'b0;
    tick(2);

    // Default run with flick held high throughout: exactly one event.
    step_en = 1'b1; flick = 1'b1;
    tick(2);  chk("b.busy_early", 32'(busy), 0);
    tick(1);  chk("b.busy", 32'(busy), 1); chk_run("b.start", 1, 0, 0);
    tick(16); chk_run("b.s16", 1, 0, 16); chk("b.led16", 32'(LED), 32'hFFFF);
    tick(1);  chk_run("b.s17", 2, 1, 16);
    tick(10); chk_run("b.s27", 2, 1, 6); chk("b.led6", 32'(LED), 32'h003F);
    tick(1);  chk_run("b.s28", 1, 2, 6);
    tick(5);  chk_run("b.s33", 1, 2, 11); chk("b.led11", 32'(LED), 32'h07FF);
    tick(1);  chk_run("b.s34", 2, 3, 11);
    tick(11); chk_run("b.s45", 2, 3, 0);
    tick(1);  chk_run("b.s46", 1, 4, 0);
    tick(6);  chk_run("b.s52", 1, 4, 6);
    tick(1);  chk_run("b.s53", 2, 5, 6);
    tick(6);  chk_run("b.s59", 2, 5, 0); chk("b.done59", 32'(done), 0);
    tick(1);  chk("b.done60", 32'(done), 1); chk_run("b.s60", 0, 0, 0);
    chk("b.led60", 32'(LED), 0); chk("b.busy60", 32'(busy), 0);
    tick(1);  chk("b.done61", 32'(done), 0); chk("b.held", 32'(current_state), 0);
    flick = 1'b0;
    tick(3);  chk("b.idle", 32'(current_state), 0);

    // Kick-back from phase 1 at level 6.
    flick = 1'b1; tick(3); flick = 1'b0;
    tick(27); chk_run("c.s27", 2, 1, 6);
    step_en = 1'b0;
    flick = 1'b1;
    tick(2);  chk("c.kick_early", 32'(kick), 0);
    tick(1);  chk("c.kick", 32'(kick), 1); chk_run("c.kicked", 1, 0, 6);
    chk("c.done_kick", 32'(done), 0);
    flick = 1'b0; step_en = 1'b1;
    tick(1);  chk("c.kick_off", 32'(kick), 0); chk_run("c.up7", 1, 0, 7);
    tick(9);  chk_run("c.up16", 1, 0, 16);
    tick(1);  chk_run("c.p1", 2, 1, 16);
    tick(20); chk_run("c.p3_8", 2, 3, 8);
    // Level 8 is not a kick point: flick ignored.
    step_en = 1'b0; flick = 1'b1;
    tick(3);  chk("c.nokick", 32'(kick), 0); chk_run("c.nokick", 2, 3, 8);
    flick = 1'b0; step_en = 1'b1;
    tick(1);  chk_run("c.p3_7", 2, 3, 7);
    tick(7);  chk_run("c.p3_0", 2, 3, 0);
    // Kick at level 0 coincides with a step: kick wins.
    step_en = 1'b0; flick = 1'b1;
    tick(2);  step_en = 1'b1;
    tick(1);  chk("c.kick0", 32'(kick), 1); chk_run("c.kick0", 1, 2, 0);
    flick = 1'b0;
    tick(1);  chk_run("c.after0", 1, 2, 1);
    tick(36); chk_run("c.s_end", 2, 5, 0); chk("c.done_early", 32'(done), 0);
    tick(1);  chk("c.done", 32'(done), 1); chk("c.idle", 32'(current_state), 0);

    // Write table[0]=20 in the same cycle as the starting event (clamped to 16).
    flick = 1'b1;
    tick(2);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 5'd20;
    tick(1);  cfg_we = 1'b0; flick = 1'b0;
    chk("d.busy", 32'(busy), 1);
    tick(16); chk_run("d.s16", 1, 0, 16);
    tick(1);  chk_run("d.s17", 2, 1, 16);
    cfg_write(2, 3);
    tick(10); chk_run("d.s28", 1, 2, 6);
    tick(5);  chk_run("d.s33", 1, 2, 11);
    tick(1);  chk_run("d.s34", 2, 3, 11);
    tick(25); chk_run("d.s59", 2, 5, 0);
    tick(1);  chk("d.done", 32'(done), 1);

    // table = {16,6,4,0,2,0}: phase 2 becomes a one-step dwell.
    cfg_write(4, 2);
    cfg_write(2, 4);
    flick = 1'b1; tick(3); flick = 1'b0;
    tick(17); chk_run("e.s17", 2, 1, 16);
    tick(11); chk_run("e.s28", 1, 2, 6);
    tick(1);  chk_run("e.s29", 2, 3, 6);
    tick(6);  chk_run("e.s35", 2, 3, 0);
    tick(1);  chk_run("e.s36", 1, 4, 0);
    tick(2);  chk_run("e.s38", 1, 4, 2);
    tick(1);  chk_run("e.s39", 2, 5, 2);
    tick(2);  chk_run("e.s41", 2, 5, 0); chk("e.done41", 32'(done), 0);
    tick(1);  chk("e.done42", 32'(done), 1);
    // table[1]=16: down phase from 16 dwells exactly one step.
    cfg_write(1, 16);
    flick = 1'b1; tick(3); flick = 1'b0;
    tick(17); chk_run("e2.s17", 2, 1, 16);
    tick(1);  chk_run("e2.s18", 1, 2, 16);
    tick(1);  chk_run("e2.s19", 2, 3, 16);
    tick(23); chk("e2.done", 32'(done), 1); chk("e2.idle", 32'(current_state), 0);

    // Asynchronous reset at level 9 in GO_UP.
    flick = 1'b1; tick(3); flick = 1'b0;
    tick(9);  chk_run("f.s9", 1, 0, 9); chk("f.led9", 32'(LED), 32'h01FF);
    #2 reset = 1'b1;
    #1;
    chk_run("f.rst", 0, 0, 0);
    chk("f.rst_led", 32'(LED), 0);
    chk("f.rst_busy", 32'(busy), 0);
    chk("f.rst_done", 32'(done), 0);
    chk("f.rst_kick", 32'(kick), 0);
    tick(2);  chk("f.rst_done2", 32'(done), 0);
    reset = 1'b0;
    tick(1);
    // Fresh run must see the default table again.
    flick = 1'b1; tick(3); flick = 1'b0;
    chk("f.busy", 32'(busy), 1);
    tick(18); chk_run("f.s18", 2, 1, 15);
    tick(10); chk_run("f.s28", 1, 2, 6);
    tick(5);  chk_run("f.s33", 1, 2, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
